// File: rtl/mem_arbiter_if.sv
// Bus bundle around mem_arbiter: the fetch and LSU request/response ports on
// the core side and the shared memory port on the other.
//   slave  : the arbiter's view (takes core requests, drives the memory port)
//   master : the surrounding core/memory view (the mirror image)
interface mem_arbiter_if;
  // fetch port
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  // LSU port
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteen;
  logic        data_gnt;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic        data_err;
  // shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_valid, instr_rdata, instr_err,
    input  data_req, data_wr, data_addr, data_wdata, data_byteen,
    output data_gnt, data_valid, data_rdata, data_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_valid, instr_rdata, instr_err,
    output data_req, data_wr, data_addr, data_wdata, data_byteen,
    input  data_gnt, data_valid, data_rdata, data_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (fetch, LSU) to one-slave memory arbiter. Round-robin on ties,
// zero added latency on request and response paths, in-order responses routed
// back via a FIFO of owner tags (0 = instr, 1 = data).
// Ports:
//   clk          core clock, all state on rising edge
//   reset_n      synchronous reset, active HIGH (legacy name)
//   bus          mem_arbiter_if.slave: fetch/LSU ports and shared memory port
//   spurious_rsp sticky flag: a response arrived with nothing outstanding
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_arbiter_if.slave        bus,
  output logic                spurious_rsp
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       last_grant_q;  // 0 = instr, 1 = data
  logic                       spurious_q;

  logic full, any_req, sel_data, push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle does not release the block: full is purely
  // registered count, which keeps req->gnt free of the rvalid path.
  assign full     = (count_q == CW'(MAX_OUTSTANDING));
  assign any_req  = bus.instr_req | bus.data_req;
  assign bus.mem_req = ~reset_n & ~full & any_req;

  // Data wins when alone or when instr had the last grant. Gated by mem_req
  // so the idle mux parks on the instr fields.
  assign sel_data = bus.mem_req & bus.data_req & (~bus.instr_req | ~last_grant_q);

  assign bus.mem_addr  = sel_data ? bus.data_addr   : bus.instr_addr;
  assign bus.mem_we    = sel_data ? bus.data_wr     : 1'b0;
  assign bus.mem_wdata = sel_data ? bus.data_wdata  : 32'h0;
  assign bus.mem_be    = sel_data ? bus.data_byteen : 4'hF;

  assign push          = bus.mem_req & bus.mem_gnt;
  assign bus.instr_gnt = push & ~sel_data;
  assign bus.data_gnt  = push & sel_data;

  // Response routing straight off the FIFO head.
  assign head = tag_q[rd_ptr_q];
  assign pop  = ~reset_n & bus.mem_rvalid & (count_q != '0);

  assign bus.instr_valid = pop & ~head;
  assign bus.data_valid  = pop & head;
  assign bus.instr_rdata = bus.mem_rdata;
  assign bus.data_rdata  = bus.mem_rdata;
  assign bus.instr_err   = bus.instr_valid & bus.mem_err;
  assign bus.data_err    = bus.data_valid & bus.mem_err;

  assign spurious_rsp = spurious_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= sel_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
        last_grant_q    <= sel_data;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.mem_rvalid && count_q == '0) spurious_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h0000_0200;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n;
  logic spurious_rsp;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .spurious_rsp(spurious_rsp)
  );

  typedef struct {
    logic ireq, dreq, dwr, gnt, rv, err;
    logic [31:0] rdata;
    logic e_mreq, e_igt, e_dgt, e_we;
    logic [3:0] e_be;
    logic [31:0] e_addr;
    logic e_iv, e_dv, e_ie, e_de, e_sp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, dreq, dwr, gnt, rv, err, input logic [31:0] rdata);
    bus.instr_req  = ireq;
    bus.data_req   = dreq;
    bus.data_wr    = dwr;
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_err    = err;
    bus.mem_rdata  = rdata;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_addr  = IA;
    bus.data_addr   = DA;
    bus.data_wdata  = WD;
    bus.data_byteen = 4'h3;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    reset_n = 1'b1;

    // ireq, dreq, dwr, gnt, rv, err, rdata | mreq igt dgt we be addr | iv dv ie de sp
    vecs[0]  = '{0,0,0,0,0,0,32'h0,   0,0,0,0,4'hF,IA, 0,0,0,0,0}; // idle
    vecs[1]  = '{1,0,0,1,0,0,32'h0,   1,1,0,0,4'hF,IA, 0,0,0,0,0}; // single fetch
    vecs[2]  = '{0,0,0,0,1,0,32'h13,  0,0,0,0,4'hF,IA, 1,0,0,0,0}; // fetch rsp
    vecs[3]  = '{1,1,1,1,0,0,32'h0,   1,0,1,1,4'h3,DA, 0,0,0,0,0}; // tie: data first
    vecs[4]  = '{1,1,1,1,0,0,32'h0,   1,1,0,0,4'hF,IA, 0,0,0,0,0}; // tie: instr next
    vecs[5]  = '{1,1,1,1,0,0,32'h0,   0,0,0,0,4'hF,IA, 0,0,0,0,0}; // full
    vecs[6]  = '{1,1,1,1,1,0,32'hAA,  0,0,0,0,4'hF,IA, 0,1,0,0,0}; // pop data, still blocked
    vecs[7]  = '{1,1,1,1,1,0,32'hBB,  1,0,1,1,4'h3,DA, 1,0,0,0,0}; // unblocked, push+pop
    vecs[8]  = '{0,0,0,0,1,1,32'hCC,  0,0,0,0,4'hF,IA, 0,1,0,1,0}; // data err
    vecs[9]  = '{0,0,0,0,1,0,32'hDD,  0,0,0,0,4'hF,IA, 0,0,0,0,0}; // spurious
    vecs[10] = '{1,0,0,1,0,0,32'h0,   1,1,0,0,4'hF,IA, 0,0,0,0,1}; // fetch after spurious
    vecs[11] = '{0,0,0,0,1,1,32'hEE,  0,0,0,0,4'hF,IA, 1,0,1,0,1}; // instr err
    vecs[12] = '{0,1,0,0,0,0,32'h0,   1,0,0,0,4'h3,DA, 0,0,0,0,1}; // load, no gnt
    vecs[13] = '{0,1,0,1,0,0,32'h0,   1,0,1,0,4'h3,DA, 0,0,0,0,1}; // load granted
    vecs[14] = '{0,0,0,0,1,0,32'h55,  0,0,0,0,4'hF,IA, 0,1,0,0,1}; // load rsp

    // Reset: outputs forced low even with requests and responses present.
    drive(1, 1, 1, 1, 1, 0, 32'h0);
    @(negedge clk);
    chk("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst gnts", {30'b0, bus.instr_gnt, bus.data_gnt}, 32'd0);
    chk("rst valids", {30'b0, bus.instr_valid, bus.data_valid}, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    reset_n = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ireq, vecs[i].dreq, vecs[i].dwr, vecs[i].gnt,
            vecs[i].rv, vecs[i].err, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d mem_req", i), {31'b0, bus.mem_req}, {31'b0, vecs[i].e_mreq});
      chk($sformatf("v%0d instr_gnt", i), {31'b0, bus.instr_gnt}, {31'b0, vecs[i].e_igt});
      chk($sformatf("v%0d data_gnt", i), {31'b0, bus.data_gnt}, {31'b0, vecs[i].e_dgt});
      chk($sformatf("v%0d mem_we", i), {31'b0, bus.mem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d mem_be", i), {28'b0, bus.mem_be}, {28'b0, vecs[i].e_be});
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, (vecs[i].e_addr == DA) ? WD : 32'h0);
      chk($sformatf("v%0d instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, vecs[i].e_iv});
      chk($sformatf("v%0d data_valid", i), {31'b0, bus.data_valid}, {31'b0, vecs[i].e_dv});
      chk($sformatf("v%0d instr_err", i), {31'b0, bus.instr_err}, {31'b0, vecs[i].e_ie});
      chk($sformatf("v%0d data_err", i), {31'b0, bus.data_err}, {31'b0, vecs[i].e_de});
      chk($sformatf("v%0d instr_rdata", i), bus.instr_rdata, vecs[i].rdata);
      chk($sformatf("v%0d data_rdata", i), bus.data_rdata, vecs[i].rdata);
      chk($sformatf("v%0d spurious", i), {31'b0, spurious_rsp}, {31'b0, vecs[i].e_sp});
      step();
    end

    // Reset mid-flight: one fetch outstanding, reset, then its late response.
    drive(1, 0, 0, 1, 0, 0, 32'h0);
    @(negedge clk);
    chk("mf grant", {31'b0, bus.instr_gnt}, 32'd1);
    step();
    reset_n = 1'b1;
    drive(1, 0, 0, 1, 1, 0, 32'h77);
    @(negedge clk);
    chk("mf rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mf rst instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    step();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("mf spurious cleared", {31'b0, spurious_rsp}, 32'd0);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'h77);
    @(negedge clk);
    chk("mf late valids", {30'b0, bus.instr_valid, bus.data_valid}, 32'd0);
    step();
    drive(1, 0, 0, 1, 0, 0, 32'h0);
    @(negedge clk);
    chk("mf spurious set", {31'b0, spurious_rsp}, 32'd1);
    chk("mf grant 1", {31'b0, bus.instr_gnt}, 32'd1);
    step();
    @(negedge clk);
    chk("mf grant 2", {31'b0, bus.instr_gnt}, 32'd1);
    step();
    @(negedge clk);
    chk("mf blocked", {31'b0, bus.mem_req}, 32'd0);
    chk("mf spurious sticky", {31'b0, spurious_rsp}, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
